// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared pattern codes, bar colours and generator states
package lcd_pkg;

    localparam logic [1:0] PAT_SOLID = 2'd0;
    localparam logic [1:0] PAT_BARS  = 2'd1;
    localparam logic [1:0] PAT_CHECK = 2'd2;
    localparam logic [1:0] PAT_GRAD  = 2'd3;

    localparam logic [15:0] BAR_WHITE   = 16'hFFFF;
    localparam logic [15:0] BAR_YELLOW  = 16'hFFE0;
    localparam logic [15:0] BAR_CYAN    = 16'h07FF;
    localparam logic [15:0] BAR_GREEN   = 16'h07E0;
    localparam logic [15:0] BAR_MAGENTA = 16'hF81F;
    localparam logic [15:0] BAR_RED     = 16'hF800;
    localparam logic [15:0] BAR_BLUE    = 16'h001F;
    localparam logic [15:0] BAR_BLACK   = 16'h0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HI   = 2'd1,
        LO   = 2'd2,
        DONE = 2'd3
    } gen_state_e;

    // Bar index 0 is the leftmost bar.
    function automatic logic [15:0] bar_color(input logic [2:0] idx);
        case (idx)
            3'd0:    bar_color = BAR_WHITE;
            3'd1:    bar_color = BAR_YELLOW;
            3'd2:    bar_color = BAR_CYAN;
            3'd3:    bar_color = BAR_GREEN;
            3'd4:    bar_color = BAR_MAGENTA;
            3'd5:    bar_color = BAR_RED;
            3'd6:    bar_color = BAR_BLUE;
            default: bar_color = BAR_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/lcd_pixel_source_if.sv
// rtl/lcd_pixel_source_if.sv - show-ahead byte FIFO read port toward lcd_ctrl
interface lcd_pixel_source_if;
    logic       fifo_rd_en;
    logic [7:0] fifo_rd_data;
    logic       fifo_empty;

    // master is the reader (lcd_ctrl), slave is the pixel source
    modport master (output fifo_rd_en, input  fifo_rd_data, input  fifo_empty);
    modport slave  (input  fifo_rd_en, output fifo_rd_data, output fifo_empty);
endinterface

// File: rtl/lcd_byte_fifo.sv
// rtl/lcd_byte_fifo.sv - show-ahead byte FIFO with count-based flags and sticky underflow
module lcd_byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       wr_en_i,
    input  logic [7:0] wr_data_i,
    input  logic       rd_en_i,
    input  logic       uf_clr_i,
    output logic [7:0] rd_data_o,
    output logic       empty_o,
    output logic       full_o,
    output logic       underflow_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          underflow_q;
    logic          push;
    logic          pop;

    // Flags come from the registered count, so a pop never unblocks a push in the same cycle.
    assign full_o      = (count_q == FULL_CNT);
    assign empty_o     = (count_q == '0);
    assign push        = wr_en_i && !full_o;
    assign pop         = rd_en_i && !empty_o;
    assign rd_data_o   = empty_o ? 8'h00 : mem_q[rd_ptr_q];
    assign underflow_o = underflow_q;

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_data_i;
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-2 depth).
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Sticky underflow; a pop on empty in the same cycle as a clear keeps it set.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                    underflow_q <= 1'b0;
        else if (rd_en_i && empty_o)  underflow_q <= 1'b1;
        else if (uf_clr_i)            underflow_q <= 1'b0;
    end

endmodule

// File: rtl/lcd_pixel_source.sv
// rtl/lcd_pixel_source.sv - RGB565 test-frame generator feeding a show-ahead byte FIFO
module lcd_pixel_source
    import lcd_pkg::*;
#(
    parameter int H_RES      = 128,
    parameter int V_RES      = 160,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start,
    input  logic [1:0]           pattern,
    input  logic [15:0]          color,
    lcd_pixel_source_if.slave    rd_if,
    output logic                 frame_busy,
    output logic                 frame_done,
    output logic                 underflow
);
    localparam int XW = $clog2(H_RES);
    localparam int YW = $clog2(V_RES);
    localparam logic [XW-1:0] X_LAST = XW'(H_RES - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_RES - 1);

    gen_state_e    state_q, state_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [1:0]    pat_q, pat_d;
    logic [15:0]   color_q, color_d;

    logic          wr_en;
    logic [7:0]    wr_data;
    logic          uf_clr;
    logic          fifo_full;

    logic [15:0]   pix;
    logic [XW+2:0] x_times8;
    logic [2:0]    bar_idx;
    logic [4:0]    grad_r;
    logic [5:0]    grad_g;

    assign x_times8 = {x_q, 3'b000};
    assign bar_idx  = 3'(x_times8 / (XW+3)'(H_RES));
    assign grad_r   = 5'(y_q >> 2);
    assign grad_g   = 6'(x_q >> 1);

    // Current pixel colour from the latched pattern and position.
    always_comb begin
        pix = 16'h0000;
        case (pat_q)
            PAT_SOLID: pix = color_q;
            PAT_BARS:  pix = bar_color(bar_idx);
            PAT_CHECK: pix = (x_q[3] ^ y_q[3]) ? color_q : 16'h0000;
            PAT_GRAD:  pix = {grad_r, grad_g, 5'b00000};
            default:   pix = 16'h0000;
        endcase
    end

    // Generator state, position and latched frame settings.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            pat_q   <= PAT_SOLID;
            color_q <= 16'h0000;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            pat_q   <= pat_d;
            color_q <= color_d;
        end
    end

    // Next-state: emit high byte then low byte per pixel, stalling while the FIFO is full.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        pat_d   = pat_q;
        color_d = color_q;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        uf_clr  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    pat_d   = pattern;
                    color_d = color;
                    x_d     = '0;
                    y_d     = '0;
                    uf_clr  = 1'b1;
                    state_d = HI;
                end
            end
            HI: begin
                if (!fifo_full) begin
                    wr_en   = 1'b1;
                    wr_data = pix[15:8];
                    state_d = LO;
                end
            end
            LO: begin
                if (!fifo_full) begin
                    wr_en   = 1'b1;
                    wr_data = pix[7:0];
                    state_d = HI;
                    if (x_q == X_LAST) begin
                        x_d = '0;
                        if (y_q == Y_LAST) state_d = DONE;
                        else               y_d     = y_q + 1'b1;
                    end else begin
                        x_d = x_q + 1'b1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign frame_busy = (state_q != IDLE);
    assign frame_done = (state_q == DONE);

    lcd_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk         (clk),
        .rstn        (rstn),
        .wr_en_i     (wr_en),
        .wr_data_i   (wr_data),
        .rd_en_i     (rd_if.fifo_rd_en),
        .uf_clr_i    (uf_clr),
        .rd_data_o   (rd_if.fifo_rd_data),
        .empty_o     (rd_if.fifo_empty),
        .full_o      (fifo_full),
        .underflow_o (underflow)
    );

endmodule

// File: tb/tb_lcd_pixel_source.sv
// tb/tb_lcd_pixel_source.sv - scoreboard bench for lcd_pixel_source
module tb_lcd_pixel_source;
    import lcd_pkg::*;

    localparam int H_RES       = 128;
    localparam int V_RES       = 160;
    localparam int DEPTH       = 16;
    localparam int FRAME_BYTES = 2 * H_RES * V_RES;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  pattern = 2'd0;
    logic [15:0] color = 16'h0000;
    logic        frame_busy, frame_done, underflow;

    lcd_pixel_source_if fifo_if ();

    lcd_pixel_source #(.H_RES(H_RES), .V_RES(V_RES), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .start      (start),
        .pattern    (pattern),
        .color      (color),
        .rd_if      (fifo_if),
        .frame_busy (frame_busy),
        .frame_done (frame_done),
        .underflow  (underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  b;
        int          pat;
        logic [15:0] col;
        int          idx;
    } exp_t;

    typedef struct {
        int          pat;
        logic [15:0] col;
        int          idx;
        logic [7:0]  val;
    } spot_t;

    exp_t  sb[$];
    spot_t spots[$];
    int    checks = 0;
    int    errors = 0;
    int    pop_cnt = 0;
    int    done_cnt = 0;
    bit    done_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference pixel straight from the pattern rules.
    function automatic logic [15:0] ref_pix(input int pat, input logic [15:0] c, input int x, input int y);
        int bar;
        case (pat)
            0: return c;
            1: begin
                bar = (x * 8) / H_RES;
                case (bar)
                    0: return 16'hFFFF;
                    1: return 16'hFFE0;
                    2: return 16'h07FF;
                    3: return 16'h07E0;
                    4: return 16'hF81F;
                    5: return 16'hF800;
                    6: return 16'h001F;
                    default: return 16'h0000;
                endcase
            end
            2: return (((x / 8) % 2) != ((y / 8) % 2)) ? c : 16'h0000;
            default: return 16'(((y / 4) % 32) * 2048 + ((x / 2) % 64) * 32);
        endcase
    endfunction

    task automatic add_spot(input int pat, input logic [15:0] col, input int idx, input logic [7:0] val);
        spot_t s;
        s.pat = pat; s.col = col; s.idx = idx; s.val = val;
        spots.push_back(s);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a start pulse and queue the whole expected frame.
    task automatic start_frame(input logic [1:0] p, input logic [15:0] c);
        exp_t e;
        logic [15:0] px;
        pattern = p;
        color   = c;
        start   = 1'b1;
        sb.delete();
        pop_cnt  = 0;
        done_cnt = 0;
        for (int y = 0; y < V_RES; y++) begin
            for (int x = 0; x < H_RES; x++) begin
                px = ref_pix(int'(p), c, x, y);
                e.pat = int'(p); e.col = c;
                e.b = px[15:8]; e.idx = 2 * (y * H_RES + x);     sb.push_back(e);
                e.b = px[7:0];  e.idx = 2 * (y * H_RES + x) + 1; sb.push_back(e);
            end
        end
        tick();
        start = 1'b0;
    endtask

    task automatic reset_mid(input string tag);
        @(posedge clk);
        #3;
        rstn = 1'b0;
        fifo_if.fifo_rd_en = 1'b0;
        sb.delete();
        #1;
        check({tag, "_rst_empty"}, fifo_if.fifo_empty, 1);
        check({tag, "_rst_busy"}, frame_busy, 0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        tick();
    endtask

    task automatic wait_not_empty(input string tag);
        int n;
        n = 0;
        while (fifo_if.fifo_empty && n < 50) begin
            tick();
            n++;
        end
        if (fifo_if.fifo_empty) check({tag, "_first_byte_timeout"}, 1, 0);
    endtask

    // Monitor: every accepted pop is compared against the scoreboard head.
    always @(negedge clk) begin : mon
        exp_t e;
        if (rstn) begin
            if (fifo_if.fifo_rd_en && !fifo_if.fifo_empty) begin
                if (sb.size() == 0) begin
                    check("sb_unexpected_byte", {24'h0, fifo_if.fifo_rd_data}, 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    checks++;
                    if (fifo_if.fifo_rd_data !== e.b) begin
                        errors++;
                        $display("FAIL sb_byte pat=%0d idx=%0d: got %02h expected %02h",
                                 e.pat, e.idx, fifo_if.fifo_rd_data, e.b);
                    end
                    foreach (spots[i]) begin
                        if (spots[i].pat == e.pat && spots[i].idx == e.idx &&
                            (spots[i].pat == 1 || spots[i].pat == 3 || spots[i].col == e.col))
                            check($sformatf("spot_p%0d_i%0d", e.pat, e.idx),
                                  {24'h0, fifo_if.fifo_rd_data}, {24'h0, spots[i].val});
                    end
                    pop_cnt++;
                end
            end
            if (done_prev) check("busy_after_done", frame_busy, 0);
            if (frame_done) done_cnt++;
            done_prev = frame_done;
        end else begin
            done_prev = 1'b0;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        int n;
        bit seen;
        fifo_if.fifo_rd_en = 1'b0;
        add_spot(0, 16'hF800, 0, 8'hF8);   add_spot(0, 16'hF800, 1, 8'h00);
        add_spot(1, 16'h0000, 0, 8'hFF);   add_spot(1, 16'h0000, 1, 8'hFF);
        add_spot(1, 16'h0000, 32, 8'hFF);  add_spot(1, 16'h0000, 33, 8'hE0);
        add_spot(1, 16'h0000, 224, 8'h00); add_spot(1, 16'h0000, 225, 8'h00);
        add_spot(2, 16'h07E0, 0, 8'h00);   add_spot(2, 16'h07E0, 1, 8'h00);
        add_spot(2, 16'h07E0, 16, 8'h07);  add_spot(2, 16'h07E0, 17, 8'hE0);
        add_spot(2, 16'h07E0, 2064, 8'h00); add_spot(2, 16'h07E0, 2065, 8'h00);
        add_spot(3, 16'h0000, FRAME_BYTES - 2, 8'h3F);
        add_spot(3, 16'h0000, FRAME_BYTES - 1, 8'hE0);

        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        tick();
        check("reset_empty", fifo_if.fifo_empty, 1);
        check("reset_busy", frame_busy, 0);
        check("reset_done", frame_done, 0);
        check("reset_underflow", underflow, 0);
        check("reset_rd_data", {24'h0, fifo_if.fifo_rd_data}, 0);

        // Pop on empty sets a sticky underflow.
        fifo_if.fifo_rd_en = 1'b1;
        tick();
        fifo_if.fifo_rd_en = 1'b0;
        check("underflow_set", underflow, 1);
        repeat (5) tick();
        check("underflow_held", underflow, 1);

        // Bars with the reader stalled; the start also clears underflow.
        start_frame(PAT_BARS, 16'($urandom));
        check("start_busy_n1", frame_busy, 1);
        check("start_empty_n1", fifo_if.fifo_empty, 1);
        check("start_clears_underflow", underflow, 0);
        tick();
        check("start_empty_n2", fifo_if.fifo_empty, 0);
        repeat (40) tick();
        check("stall_count", {27'h0, dut.u_fifo.count_q}, DEPTH);
        check("stall_busy", frame_busy, 1);
        check("stall_not_empty", fifo_if.fifo_empty, 0);
        for (int i = 0; i < 600; i++) begin
            fifo_if.fifo_rd_en = ($urandom_range(0, 3) != 0);
            tick();
        end
        reset_mid("bars");

        // Checker 07E0 with a random reader, far enough to pass line 8.
        start_frame(PAT_CHECK, 16'h07E0);
        n = 0;
        while (pop_cnt < 2100 && n < 20000) begin
            fifo_if.fifo_rd_en = ($urandom_range(0, 3) != 0);
            tick();
            n++;
        end
        if (pop_cnt < 2100) check("check_progress_timeout", 1, 0);
        reset_mid("check");

        // Solid F800 with reader held, aborted by an asynchronous reset.
        start_frame(PAT_SOLID, 16'hF800);
        wait_not_empty("solid");
        fifo_if.fifo_rd_en = 1'b1;
        repeat (300) tick();
        check("solid_no_underflow", underflow, 0);
        reset_mid("solid");

        // Random patterns, colours and reader stalls.
        for (int k = 0; k < 2; k++) begin
            start_frame(2'($urandom_range(0, 3)), 16'($urandom));
            for (int i = 0; i < 400; i++) begin
                fifo_if.fifo_rd_en = ($urandom_range(0, 2) != 0);
                tick();
            end
            reset_mid("rand");
        end

        // Full gradient frame with an ignored second start.
        start_frame(PAT_GRAD, 16'($urandom));
        wait_not_empty("grad");
        fifo_if.fifo_rd_en = 1'b1;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 45000) begin
            if (n == 1000) begin
                pattern = PAT_SOLID;
                color   = 16'($urandom);
                start   = 1'b1;
            end
            tick();
            start = 1'b0;
            if (frame_done) seen = 1'b1;
            n++;
        end
        if (!seen) begin
            check("grad_done_timeout", 0, 1);
        end else begin
            check("grad_underflow_at_done", underflow, 0);
            repeat (4) tick();
            check("grad_underflow_overrun", underflow, 1);
            check("grad_byte_count", pop_cnt, FRAME_BYTES);
            check("grad_sb_drained", sb.size(), 0);
            check("grad_done_pulses", done_cnt, 1);
            check("grad_busy_end", frame_busy, 0);
            check("grad_empty_end", fifo_if.fifo_empty, 1);
        end
        fifo_if.fifo_rd_en = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
